// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard, branch and MEM-request signals exchanged between the pipeline and the stall/flush scheduler.
// The pipeline drives through the master modport. The scheduler receives through the slave modport.
interface pipeline_stall_ctrl_if;
    logic [3:0] id_src1;
    logic [3:0] id_src2;
    logic       id_two_src;
    logic       id_use_src1;
    logic [3:0] exe_dest;
    logic       exe_wb_en;
    logic       exe_mem_r_en;
    logic [3:0] mem_dest;
    logic       mem_wb_en;
    logic       fwd_en;
    logic       branch_taken;
    logic       mem_r_req;
    logic       mem_w_req;
    logic       hazard;
    logic       freeze_if;
    logic       freeze_pipe;
    logic       flush_if_id;
    logic       flush_id_exe;
    logic       mem_busy;
    logic       mem_done;

    modport slave (
        input  id_src1, id_src2, id_two_src, id_use_src1,
        input  exe_dest, exe_wb_en, exe_mem_r_en,
        input  mem_dest, mem_wb_en, fwd_en,
        input  branch_taken, mem_r_req, mem_w_req,
        output hazard, freeze_if, freeze_pipe,
        output flush_if_id, flush_id_exe, mem_busy, mem_done
    );

    modport master (
        output id_src1, id_src2, id_two_src, id_use_src1,
        output exe_dest, exe_wb_en, exe_mem_r_en,
        output mem_dest, mem_wb_en, fwd_en,
        output branch_taken, mem_r_req, mem_w_req,
        input  hazard, freeze_if, freeze_pipe,
        input  flush_if_id, flush_id_exe, mem_busy, mem_done
    );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: RAW hazards, SRAM wait states and branch flushes.
// Optional macro STALL_PERF_CNT_EN adds saturating freeze/hazard cycle counters.
module pipeline_stall_ctrl #(
    parameter int SRAM_WAIT = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_stall_ctrl_if.slave   bus
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [31:0]            perf_freeze_cycles,
    output logic [31:0]            perf_hazard_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(SRAM_WAIT - 1);

    state_t     state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;
    logic       mem_busy_reg;
    logic       mem_req;
    logic       mem_freeze;
    logic       raw_hazard;
    logic [3:0] src_vec [2];
    logic [1:0] live_vec;
    logic [1:0] src_hazard;

    assign mem_req = bus.mem_r_req | bus.mem_w_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= 4'd0;
            mem_busy_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            mem_busy_reg <= (state_next != IDLE);
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        mem_freeze = 1'b0;
        case (state_reg)
            IDLE: begin
                if (mem_req) begin
                    mem_freeze = 1'b1;
                    cnt_next   = WAIT_LOAD;
                    state_next = (SRAM_WAIT > 1) ? ACCESS : DONE;
                end
            end
            ACCESS: begin
                mem_freeze = 1'b1;
                cnt_next   = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // The completing instruction still holds its request; it must not restart an access.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    assign src_vec[0] = bus.id_src1;
    assign src_vec[1] = bus.id_src2;
    assign live_vec   = {bus.id_two_src, bus.id_use_src1};

    // With forwarding only a load in EXE cannot supply its result in time.
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        assign src_hazard[gi] = live_vec[gi] & (bus.fwd_en
            ? (bus.exe_mem_r_en & (src_vec[gi] == bus.exe_dest))
            : ((bus.exe_wb_en & (src_vec[gi] == bus.exe_dest)) |
               (bus.mem_wb_en & (src_vec[gi] == bus.mem_dest))));
    end

    assign raw_hazard = |src_hazard;

    always_comb begin
        bus.hazard       = raw_hazard & ~mem_freeze;
        bus.freeze_pipe  = mem_freeze;
        bus.freeze_if    = mem_freeze | raw_hazard;
        // A branch held in EXE by a freeze re-asserts once the freeze drops.
        bus.flush_if_id  = bus.branch_taken & ~mem_freeze;
        bus.flush_id_exe = bus.branch_taken & ~mem_freeze;
        bus.mem_busy     = mem_busy_reg;
        bus.mem_done     = (state_reg == DONE);
    end

`ifdef STALL_PERF_CNT_EN
    logic [31:0] perf_freeze_reg;
    logic [31:0] perf_hazard_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_freeze_reg <= 32'd0;
            perf_hazard_reg <= 32'd0;
        end else begin
            if (mem_freeze && (perf_freeze_reg != 32'hFFFF_FFFF)) begin
                perf_freeze_reg <= perf_freeze_reg + 32'd1;
            end
            if (bus.hazard && (perf_hazard_reg != 32'hFFFF_FFFF)) begin
                perf_hazard_reg <= perf_hazard_reg + 32'd1;
            end
        end
    end

    assign perf_freeze_cycles = perf_freeze_reg;
    assign perf_hazard_cycles = perf_hazard_reg;
`endif

endmodule
